screen_frame_ctrl: RTL and testbench

- Frame sequencer for the byte-level screen UART transmitter.
- Builds a screen command frame from a 16-byte payload buffer: header 0x5A 0xA5, LEN, CMD, payload, optional checksum.
- Feeds the transmitter one byte at a time via tx_data/tx_flash and paces on its tx_finish status.
- Also generates the bps_en baud square wave that the transmitter consumes.

---
 rtl/screen_frame_ctrl.sv | 102 ++++++++++
 tb/tb_screen_frame_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/screen_frame_ctrl.sv
// screen_frame_ctrl: sequences 5A A5 LEN CMD payload SUM frames into a byte UART transmitter and generates its baud enable
module screen_frame_ctrl #(
  parameter int CLK_DIV   = 868,
  parameter int FLASH_CYC = 2,
  parameter int TO_CYC    = 16,
  parameter int SUM_EN    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [7:0] cmd,
  input  logic [4:0] pay_len,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       bps_en,
  output logic [7:0] tx_data,
  output logic       tx_flash,
  input  logic       tx_finish
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int FW = $clog2(FLASH_CYC + 1);
  localparam int TW = $clog2(TO_CYC + 1);
  typedef enum logic [2:0] {IDLE, LOAD, FLASH, WAIT_BUSY, WAIT_DONE, NEXT} state_t;
  state_t state, state_n;
  logic [CW-1:0] bcnt;
  logic [FW-1:0] fcnt;
  logic [TW-1:0] tcnt;
  logic [7:0] mem [16];
  logic [7:0] cmd_r, sum, cur, len_byte;
  logic [4:0] len_r, idx, last_idx;
  logic last, timeout;
  assign last_idx = len_r + 5'(3 + SUM_EN);
  assign last = idx == last_idx;
  assign len_byte = 8'(len_r) + 8'(1 + SUM_EN);
  assign timeout = tx_finish && tcnt >= TW'(TO_CYC - 1);
  always_comb
    cur = idx == 5'd0 ? 8'h5A :
          idx == 5'd1 ? 8'hA5 :
          idx == 5'd2 ? len_byte :
          idx == 5'd3 ? cmd_r :
          idx < len_r + 5'd4 ? mem[4'(idx - 5'd4)] : sum;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = start ? LOAD : IDLE;
      LOAD:      state_n = FLASH;
      FLASH:     state_n = fcnt == FW'(FLASH_CYC - 1) ? WAIT_BUSY : FLASH;
      WAIT_BUSY: state_n = !tx_finish ? WAIT_DONE : timeout ? IDLE : WAIT_BUSY;
      WAIT_DONE: state_n = tx_finish ? NEXT : WAIT_DONE;
      NEXT:      state_n = last ? IDLE : LOAD;
      default:   state_n = IDLE;
    endcase
  end
  // buffer is deliberately not reset; it is frozen while a frame is in flight
  always_ff @(posedge clk)
    if (wr_en && !busy) mem[wr_addr] <= wr_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      bcnt     <= '0;
      bps_en   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      tx_flash <= 1'b0;
      tx_data  <= 8'h00;
      fcnt     <= '0;
      tcnt     <= '0;
      idx      <= '0;
      sum      <= '0;
      cmd_r    <= '0;
      len_r    <= '0;
    end else begin
      state    <= state_n;
      bcnt     <= bcnt == CW'(CLK_DIV - 1) ? '0 : bcnt + 1'b1;
      bps_en   <= bcnt < CW'(CLK_DIV / 2);
      busy     <= state_n != IDLE;
      tx_flash <= state_n == FLASH;
      done     <= state == NEXT && last;
      err      <= state == WAIT_BUSY && timeout;
      if (state == IDLE && start) begin
        cmd_r <= cmd;
        len_r <= pay_len > 5'd16 ? 5'd16 : pay_len;
        idx   <= '0;
        sum   <= '0;
      end
      if (state == LOAD) begin
        tx_data <= cur;
        fcnt    <= '0;
        tcnt    <= '0;
        if (idx >= 5'd3 && idx < len_r + 5'd4) sum <= sum + cur;
      end
      if (state == FLASH) fcnt <= fcnt + 1'b1;
      // timeout window is measured from the tx_flash rise, so it spans FLASH too
      if (state == FLASH || state == WAIT_BUSY) tcnt <= tcnt + 1'b1;
      if (state == NEXT) idx <= idx + 1'b1;
    end
endmodule

// File: tb/tb_screen_frame_ctrl.sv
// tb_screen_frame_ctrl: directed frames checked against a byte scoreboard fed by a simple transmitter model
module tb_screen_frame_ctrl;
  localparam int TO_CYC = 16;
  localparam int SUM_EN = 1;
  logic clk = 0, rst = 1, wr_en = 0, start = 0, tx_finish = 1;
  logic [3:0] wr_addr = 0;
  logic [7:0] wr_data = 0, cmd = 0;
  logic [4:0] pay_len = 0;
  logic busy, done, err, bps_en, tx_flash;
  logic [7:0] tx_data;
  always #5 clk = ~clk;
  screen_frame_ctrl dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cmd(cmd), .pay_len(pay_len), .start(start), .busy(busy), .done(done),
    .err(err), .bps_en(bps_en), .tx_data(tx_data), .tx_flash(tx_flash),
    .tx_finish(tx_finish)
  );
  int total = 0, bad = 0;
  logic [7:0] q[$];
  logic [7:0] mem_m [16];
  int mode = 1;
  int cyc = 0, rises = 0, n_done = 0, n_err = 0, last_rise = 0, cnt = 0;
  logic pf = 0, pb = 0;
  logic [7:0] cap = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(posedge clk) cyc++;
  // mode 0: transmitter never goes busy; 1: short fixed busy; 2: busy for 10 baud periods
  always @(negedge clk) begin
    if (done) n_done++;
    if (err) n_err++;
    if (tx_flash && !pf) begin
      rises++;
      last_rise = cyc;
      cap = tx_data;
      if (q.size() == 0) chk("extra_byte", {24'd0, tx_data}, 32'h100);
      else chk("byte", {24'd0, tx_data}, {24'd0, q.pop_front()});
      if (mode != 0) begin
        tx_finish = 0;
        cnt = mode == 1 ? 5 : 10;
      end
    end else if (!tx_finish) begin
      if (mode == 1) cnt--;
      else if (bps_en && !pb) begin
        cnt--;
        chk("tx_data_stable", {24'd0, tx_data}, {24'd0, cap});
      end
      if (cnt <= 0) tx_finish = 1;
    end
    pf = tx_flash;
    pb = bps_en;
  end
  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1; wr_addr = a; wr_data = d;
    mem_m[a] = d;
    @(negedge clk);
    wr_en = 0;
  endtask
  task automatic go(input logic [7:0] c, input logic [4:0] pl);
    int n;
    logic [7:0] s;
    n = pl > 16 ? 16 : int'(pl);
    s = c;
    q.push_back(8'h5A);
    q.push_back(8'hA5);
    q.push_back(8'(1 + n + SUM_EN));
    q.push_back(c);
    for (int i = 0; i < n; i++) begin
      q.push_back(mem_m[i]);
      s = s + mem_m[i];
    end
    if (SUM_EN != 0) q.push_back(s);
    @(negedge clk);
    start = 1; cmd = c; pay_len = pl;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_done(input string tag, input int lim);
    int low, k;
    low = 0;
    for (k = 0; k < lim && !done; k++) begin
      if (!busy) low++;
      @(negedge clk);
    end
    chk({tag, "_done_seen"}, k < lim, 1);
    chk({tag, "_busy_held"}, low, 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int k, r0, d0, e0, hi, lo;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_bps_en", bps_en, 0);
    chk("rst_tx_flash", tx_flash, 0);
    chk("rst_tx_data", {24'd0, tx_data}, 0);
    rst = 0;
    for (k = 0; k < 2000 && !bps_en; k++) @(negedge clk);
    for (k = 0; k < 2000 && bps_en; k++) @(negedge clk);
    for (k = 0; k < 2000 && !bps_en; k++) @(negedge clk);
    hi = 0;
    while (bps_en && hi < 2000) begin hi++; @(negedge clk); end
    lo = 0;
    while (!bps_en && lo < 2000) begin lo++; @(negedge clk); end
    chk("bps_high", hi, 434);
    chk("bps_low", lo, 434);
    chk("bps_period", hi + lo, 868);
    wr(0, 8'h10); wr(1, 8'h20); wr(2, 8'h30);
    r0 = rises; d0 = n_done;
    go(8'h82, 5'd3);
    repeat (20) @(negedge clk);
    wr_en = 1; wr_addr = 0; wr_data = 8'hFF; start = 1; cmd = 8'h11; pay_len = 5'd1;
    @(negedge clk);
    wr_en = 0; start = 0;
    wait_done("nominal", 400);
    go(8'h82, 5'd3);
    wait_done("b2b", 400);
    repeat (50) @(negedge clk);
    chk("nominal_rises", rises - r0, 16);
    chk("nominal_done_count", n_done - d0, 2);
    chk("nominal_idle_after", busy, 0);
    chk("nominal_queue_empty", q.size(), 0);
    mode = 2;
    go(8'h83, 5'd0);
    wait_done("empty_baud", 60000);
    repeat (5) @(negedge clk);
    mode = 1;
    chk("empty_queue_empty", q.size(), 0);
    for (int i = 0; i < 16; i++) wr(4'(i), 8'($urandom));
    r0 = rises;
    go(8'($urandom), 5'd20);
    wait_done("len20", 1000);
    repeat (3) @(negedge clk);
    chk("len20_rises", rises - r0, 21);
    chk("len20_queue_empty", q.size(), 0);
    mode = 0;
    r0 = rises; d0 = n_done; e0 = n_err;
    go(8'h44, 5'd2);
    for (k = 0; k < 200 && !err; k++) @(negedge clk);
    chk("err_seen", k < 200, 1);
    chk("err_latency", cyc - last_rise, TO_CYC);
    chk("err_busy_low", busy, 0);
    @(negedge clk);
    chk("err_one_cycle", err, 0);
    repeat (20) @(negedge clk);
    chk("timeout_rises", rises - r0, 1);
    chk("timeout_err_count", n_err - e0, 1);
    chk("timeout_no_done", n_done - d0, 0);
    q.delete();
    mode = 1;
    r0 = rises; d0 = n_done;
    go(8'h82, 5'd3);
    for (k = 0; k < 300 && rises - r0 < 3; k++) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_tx_flash", tx_flash, 0);
    chk("midrst_done", done, 0);
    chk("midrst_bps_en", bps_en, 0);
    chk("midrst_tx_data", {24'd0, tx_data}, 0);
    q.delete();
    @(negedge clk);
    rst = 0;
    repeat (10) @(negedge clk);
    chk("midrst_no_done", n_done - d0, 0);
    r0 = rises;
    go(8'h82, 5'd3);
    wait_done("after_rst", 400);
    repeat (3) @(negedge clk);
    chk("after_rst_rises", rises - r0, 8);
    chk("after_rst_queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
